serial_block_adder_ctrl: RTL and testbench
==========================================

SERIAL_BLOCK_ADDER_CTRL -- requirements
Module: serial_block_adder_ctrl

Interface
REQ-001 SHALL have parameter BLOCK_LEN, default from the shared defines header (4): bits added per cycle.
REQ-002 SHALL have parameter NUM_BLOCKS, default 8: blocks per operand; W = BLOCK_LEN*NUM_BLOCKS (default 32).
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): operand handshake.
REQ-006 SHALL have ports a and b (input, W each) and cin (input, 1): operands and carry-in.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-008 SHALL have ports sum (output, W) and cout (output, 1): result and final carry.
REQ-009 SHALL have port busy (output, 1): high in RUN or DONE.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE; IDLE after reset.
REQ-011 IDLE: in_ready=1; on in_valid&in_ready, latch a, b; carry reg <- cin; idx <- 0; clear sum reg; go RUN.
REQ-012 RUN: each cycle add slice idx of a, b plus carry reg; write BLOCK_LEN-bit result to sum[idx*BLOCK_LEN +: BLOCK_LEN]; carry reg <- slice carry-out; idx++.
REQ-013 RUN -> DONE on the cycle slice NUM_BLOCKS-1 is written; idx SHALL never wrap past NUM_BLOCKS-1.
REQ-014 Latency: accept at edge 0 -> out_valid high after edge NUM_BLOCKS+1 (default 9); fixed, data-independent.
REQ-015 DONE: out_valid=1; cout = final carry reg; sum, cout held stable until out_valid&out_ready; then go IDLE.
REQ-016 in_ready SHALL be 0 in RUN and DONE; in_valid is ignored there; no accept in the DONE->IDLE handshake cycle.
REQ-017 out_valid SHALL be 0 outside DONE; sum holds partial results during RUN and is not valid until DONE.
REQ-018 Arithmetic modulo 2^W; the carry out of the MSB slice goes to cout only.

Reset
REQ-019 rst_n low SHALL asynchronously force IDLE, idx=0, carry=0, sum=0, cout=0, out_valid=0, busy=0, in_ready=1 (in_ready is a decode of IDLE).
REQ-020 Reset during RUN or DONE SHALL abort the operation; no result is delivered; first accept possible on the first edge after release.

Configuration
REQ-021 Macro SERIAL_ADDER_SUB_EN: when defined, add input port sub (1 bit), latched with operands; sub=1 latches ~b and forces the initial carry to 1 (cin ignored), giving a-b.
REQ-022 Without SERIAL_ADDER_SUB_EN: no sub port; the block only adds a+b+cin.

Structure
REQ-023 BLOCK_LEN and the FSM state encoding SHALL live in the shared adder defines header/package.
REQ-024 SHALL instantiate one sub-module, block_slice_adder: combinational BLOCK_LEN-bit add with carry-in and carry-out. All sequencing stays in the parent.

Verification (BLOCK_LEN=4, NUM_BLOCKS=8)
REQ-025 a=0x00000001, b=0x00000002, cin=0 -> sum=0x00000003, cout=0; out_valid first high 9 edges after accept.
REQ-026 a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1; the carry ripples through all 8 slices.
REQ-027 a=0x80000000, b=0x80000000, cin=1 -> sum=0x00000001, cout=1.
REQ-028 out_ready held 0 for 5 cycles in DONE, in_valid held 1 -> sum/cout stable, in_ready=0, no second accept; IDLE on the cycle after out_ready=1.
REQ-029 rst_n pulsed low at RUN cycle 4 -> out_valid=0, sum=0, busy=0 immediately; in_ready=1; a new operand is accepted on the first edge after release.
REQ-030 With SERIAL_ADDER_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0; a=7, b=5, sub=1 -> sum=0x00000002, cout=1.

Source files
------------

// File: rtl/serial_block_adder_ctrl_pkg.sv
// Shared adder defines: default slice width and FSM state encoding.
package serial_block_adder_ctrl_pkg;

  localparam int BLOCK_LEN_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int num_blocks);
    return (num_blocks > 1) ? $clog2(num_blocks) : 1;
  endfunction

endpackage

// File: rtl/serial_block_adder_ctrl_slice.sv
// block_slice_adder: purely combinational BLOCK_LEN-bit add with carry in/out.
module block_slice_adder
  import serial_block_adder_ctrl_pkg::*;
#(
  parameter int BLOCK_LEN = BLOCK_LEN_DEF
) (
  input  logic [BLOCK_LEN-1:0] a_i,
  input  logic [BLOCK_LEN-1:0] b_i,
  input  logic                 c_i,
  output logic [BLOCK_LEN-1:0] s_o,
  output logic                 c_o
);

  logic [BLOCK_LEN:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i} + {{BLOCK_LEN{1'b0}}, c_i};
  assign s_o      = full_sum[BLOCK_LEN-1:0];
  assign c_o      = full_sum[BLOCK_LEN];

endmodule

// File: rtl/serial_block_adder_ctrl.sv
// Serial block adder: one BLOCK_LEN slice per cycle, result held until taken.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADDER_SUB_EN.
//   state   | meaning
//   IDLE    | in_ready high, waiting for an operand pair
//   RUN     | adding slice idx, carry rippling through carry_q
//   DONE    | result published (out_valid raised one cycle after entry), held until out_ready
module serial_block_adder_ctrl
  import serial_block_adder_ctrl_pkg::*;
#(
  parameter int BLOCK_LEN  = BLOCK_LEN_DEF,
  parameter int NUM_BLOCKS = 8,
  parameter int W          = BLOCK_LEN * NUM_BLOCKS
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int IDX_W = idx_width(NUM_BLOCKS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BLOCKS - 1);

  state_e               state_q;
  logic [W-1:0]         a_q;
  logic [W-1:0]         b_q;
  logic [W-1:0]         sum_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 carry_q;
  logic                 cout_q;
  logic                 out_valid_q;

  logic [BLOCK_LEN-1:0] slice_a_d;
  logic [BLOCK_LEN-1:0] slice_b_d;
  logic [BLOCK_LEN-1:0] slice_sum_d;
  logic                 slice_carry_d;
  logic [W-1:0]         b_load_d;
  logic                 carry_load_d;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's complement subtract: a + ~b + 1, so the incoming carry is ignored.
  assign b_load_d     = sub ? ~b : b;
  assign carry_load_d = sub ? 1'b1 : cin;
`else
  assign b_load_d     = b;
  assign carry_load_d = cin;
`endif

  assign slice_a_d = a_q[idx_q*BLOCK_LEN +: BLOCK_LEN];
  assign slice_b_d = b_q[idx_q*BLOCK_LEN +: BLOCK_LEN];

  block_slice_adder #(
    .BLOCK_LEN(BLOCK_LEN)
  ) u_slice (
    .a_i (slice_a_d),
    .b_i (slice_b_d),
    .c_i (carry_q),
    .s_o (slice_sum_d),
    .c_o (slice_carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q         <= a;
            b_q         <= b_load_d;
            carry_q     <= carry_load_d;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            state_q     <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[idx_q*BLOCK_LEN +: BLOCK_LEN] <= slice_sum_d;
          carry_q <= slice_carry_d;
          if (idx_q == IDX_LAST) begin
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          // The extra publish cycle keeps latency at NUM_BLOCKS+1 edges.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            cout_q      <= carry_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          idx_q       <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_block_adder_ctrl.sv
// Bench for serial_block_adder_ctrl: arithmetic/timing model plus directed vectors.
module tb_serial_block_adder_ctrl;

  localparam int BL  = 4;
  localparam int NB  = 8;
  localparam int W   = BL * NB;
  localparam int LAT = NB + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  serial_block_adder_ctrl #(.BLOCK_LEN(BL), .NUM_BLOCKS(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transaction completes LAT edges after acceptance with {cout,sum} = a + b + cin.
  logic         m_idle = 1'b1;
  int           m_k = 0;
  logic         m_fresh = 1'b1;
  logic [W:0]   m_exp = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle  <= 1'b1;
      m_k     <= 0;
      m_fresh <= 1'b1;
    end else if (m_idle) begin
      if (in_valid) begin
        logic [W-1:0] b_eff;
        logic         c_eff;
        b_eff = b;
        c_eff = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
          b_eff = ~b;
          c_eff = 1'b1;
        end
`endif
        m_exp   <= {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, c_eff};
        m_idle  <= 1'b0;
        m_k     <= 0;
        m_fresh <= 1'b0;
      end
    end else if (m_k >= LAT) begin
      if (out_ready) m_idle <= 1'b1;
    end else begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {63'd0, in_ready}, {63'd0, m_idle});
    chk("busy", {63'd0, busy}, {63'd0, !m_idle});
    chk("out_valid", {63'd0, out_valid}, {63'd0, (!m_idle && m_k >= LAT)});
    if (m_fresh) begin
      chk("reset_sum", {32'd0, sum}, 64'd0);
      chk("reset_cout", {63'd0, cout}, 64'd0);
    end
    if (!m_idle && m_k >= LAT) begin
      chk("sum", {32'd0, sum}, {32'd0, m_exp[W-1:0]});
      chk("cout", {63'd0, cout}, {63'd0, m_exp[W]});
    end
  end

  // Drives one operand pair from mid-cycle, checks latency, result and handshake.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input int hold, input logic [W-1:0] es, input logic ec);
    int lat;
    logic [W-1:0] held_sum;
    logic         held_cout;
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(LAT));
    if (!out_valid) begin
      $display("FAIL timeout: out_valid never rose");
      return;
    end
    chk("lit_sum", {32'd0, sum}, {32'd0, es});
    chk("lit_cout", {63'd0, cout}, {63'd0, ec});
    held_sum = sum;
    held_cout = cout;
    if (hold > 0) begin
      in_valid = 1'b1;
      a = ~ta; b = ~tb_v;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
      end
      chk("hold_sum", {32'd0, sum}, {32'd0, held_sum});
      chk("hold_cout", {63'd0, cout}, {63'd0, held_cout});
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_valid", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0, 32'h0000_0003, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h0000_0000, 1'b1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 32'h0000_0001, 1'b1);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0, 32'hACF1_3569, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5, 32'hFFFF_FFFF, 1'b1);

    // Abort mid-run, then accept on the first edge after release.
    a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_sum", {32'd0, sum}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    #1;
    rst_n = 1'b1;
    run_op(32'h0000_0010, 32'h0000_0020, 1'b1, 0, 32'h0000_0031, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op(32'd5, 32'd7, 1'b0, 0, 32'hFFFF_FFFE, 1'b0);
    run_op(32'd7, 32'd5, 1'b0, 0, 32'h0000_0002, 1'b1);
    sub = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
